// File: rtl/bcd_alu_sequencer_pkg.sv
// Shared definitions for the BCD ALU sequencer: op codes, FSM encoding and
// digit-serial BCD helpers (validity check, +/-1 step).
package calc_pkg;
  localparam int DIGIT_W    = 4;
  localparam int MAX_DIGITS = 8;
  localparam int MAX_W      = DIGIT_W * MAX_DIGITS;

  localparam logic [3:0] OP_EQUAL = 4'd10;
  localparam logic [3:0] OP_AC    = 4'd11;
  localparam logic [3:0] OP_PLUS  = 4'd12;
  localparam logic [3:0] OP_MINUS = 4'd13;
  localparam logic [3:0] OP_MULT  = 4'd14;
  localparam logic [3:0] OP_DIV   = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_EXEC   = 2'b01,
    S_ITER   = 2'b10,
    S_FINISH = 2'b11
  } seq_state_e;

  // Counters are narrow so they get a ripple +/-1 instead of the shared adder.
  function automatic logic [MAX_W-1:0] bcd_step(input logic [MAX_W-1:0] x,
                                                input logic dec, input int n);
    logic [MAX_W-1:0] y;
    logic [3:0]       d;
    logic             c;
    y = x;
    c = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      d = x[i*DIGIT_W +: DIGIT_W];
      if (c && i < n) begin
        if (dec) begin
          if (d == 4'd0) d = 4'd9;
          else begin d = d - 4'd1; c = 1'b0; end
        end else begin
          if (d == 4'd9) d = 4'd0;
          else begin d = d + 4'd1; c = 1'b0; end
        end
      end
      y[i*DIGIT_W +: DIGIT_W] = d;
    end
    return y;
  endfunction

  function automatic logic is_bcd(input logic [MAX_W-1:0] x);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++)
      if (x[i*DIGIT_W +: DIGIT_W] > 4'd9) ok = 1'b0;
    return ok;
  endfunction
endpackage

// File: rtl/bcd_alu_sequencer_if.sv
// Request/result bundle between the calculator FSM (master) and the sequencer.
// Optional remainder port: BCD_SEQ_REMAINDER_EN.
interface bcd_alu_sequencer_if #(parameter int DIGITS = 4);
  import calc_pkg::*;
  localparam int W = DIGIT_W * DIGITS;

  logic         start;
  logic [3:0]   op;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         neg;
  logic         err;
  logic [1:0]   state;
`ifdef BCD_SEQ_REMAINDER_EN
  logic [W-1:0] rem;

  modport master (output start, op, opa, opb,
                  input  busy, done, result, neg, err, state, rem);
  modport slave  (input  start, op, opa, opb,
                  output busy, done, result, neg, err, state, rem);
`else
  modport master (output start, op, opa, opb,
                  input  busy, done, result, neg, err, state);
  modport slave  (input  start, op, opa, opb,
                  output busy, done, result, neg, err, state);
`endif
endinterface

// File: rtl/bcd_alu_sequencer_addsub.sv
// Combinational DIGITS-wide BCD adder/subtractor; cout is carry (add) or
// borrow (sub) out of the top digit.
module bcd_addsub
  import calc_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic [DIGIT_W*DIGITS-1:0] a,
  input  logic [DIGIT_W*DIGITS-1:0] b,
  input  logic                      sub,
  output logic [DIGIT_W*DIGITS-1:0] y,
  output logic                      cout
);
  logic [DIGITS:0] c;
  assign c[0] = 1'b0;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    logic [4:0] raw;
    logic [3:0] dig;
    logic       co;
    // 5-bit per-digit sum keeps the correction local: +6 on add, +10 on borrow.
    always_comb begin
      if (sub) begin
        raw = {1'b0, a[g*DIGIT_W +: DIGIT_W]} - {1'b0, b[g*DIGIT_W +: DIGIT_W]}
              - {4'b0, c[g]};
        co  = raw[4];
        dig = co ? raw[3:0] + 4'd10 : raw[3:0];
      end else begin
        raw = {1'b0, a[g*DIGIT_W +: DIGIT_W]} + {1'b0, b[g*DIGIT_W +: DIGIT_W]}
              + {4'b0, c[g]};
        co  = (raw > 5'd9);
        dig = co ? raw[3:0] + 4'd6 : raw[3:0];
      end
    end
    assign y[g*DIGIT_W +: DIGIT_W] = dig;
    assign c[g+1] = co;
  end

  assign cout = c[DIGITS];
endmodule

// File: rtl/bcd_alu_sequencer.sv
// Sequences one shared BCD add/sub datapath through PLUS/MINUS (single pass),
// MULT (repeated add) and DIV (repeated subtract). Optional: BCD_SEQ_REMAINDER_EN.
module bcd_alu_sequencer
  import calc_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input logic                 clk,
  input logic                 reset,
  bcd_alu_sequencer_if.slave  bus
);
  localparam int W = DIGIT_W * DIGITS;

  seq_state_e   state_q;
  logic [3:0]   op_q;
  logic [W-1:0] opa_q, opb_q, acc_q, cnt_q, result_q;
  logic         busy_q, done_q, neg_q, err_q;
`ifdef BCD_SEQ_REMAINDER_EN
  logic [W-1:0] rem_q;
`endif

  logic [W-1:0] add_a, add_b, add_y;
  logic         add_sub, add_co;
  logic [W-1:0] cnt_dec_d, cnt_inc_d;
  logic         ops_ok, a_lt_b;

  // Valid BCD orders the same as its raw binary encoding.
  assign a_lt_b    = (opa_q < opb_q);
  assign ops_ok    = (op_q >= OP_PLUS) && is_bcd(MAX_W'(opa_q)) && is_bcd(MAX_W'(opb_q));
  assign cnt_dec_d = W'(bcd_step(MAX_W'(cnt_q), 1'b1, DIGITS));
  assign cnt_inc_d = W'(bcd_step(MAX_W'(cnt_q), 1'b0, DIGITS));

  // acc_q is the MULT accumulator or the DIV running remainder; cnt_q is the
  // MULT down-counter or the DIV quotient.
  always_comb begin
    add_a   = opa_q;
    add_b   = opb_q;
    add_sub = 1'b0;
    if (state_q == S_EXEC && op_q == OP_MINUS) begin
      add_sub = 1'b1;
      if (a_lt_b) begin
        add_a = opb_q;
        add_b = opa_q;
      end
    end else if (state_q == S_ITER) begin
      add_a   = acc_q;
      add_b   = (op_q == OP_MULT) ? opa_q : opb_q;
      add_sub = (op_q != OP_MULT);
    end
  end

  bcd_addsub #(.DIGITS(DIGITS)) u_addsub (
    .a    (add_a),
    .b    (add_b),
    .sub  (add_sub),
    .y    (add_y),
    .cout (add_co)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
`ifdef BCD_SEQ_REMAINDER_EN
      rem_q    <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (bus.start) begin
          op_q     <= bus.op;
          opa_q    <= bus.opa;
          opb_q    <= bus.opb;
          result_q <= '0;
          neg_q    <= 1'b0;
          err_q    <= 1'b0;
`ifdef BCD_SEQ_REMAINDER_EN
          rem_q    <= '0;
`endif
          busy_q   <= 1'b1;
          state_q  <= S_EXEC;
        end
        S_EXEC: begin
          state_q <= S_FINISH;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          if (!ops_ok) begin
            err_q <= 1'b1;
          end else begin
            case (op_q)
              OP_PLUS: begin
                if (add_co) err_q <= 1'b1;
                else        result_q <= add_y;
              end
              OP_MINUS: begin
                result_q <= add_y;
                neg_q    <= a_lt_b;
              end
              OP_MULT: begin
                acc_q <= '0;
                cnt_q <= opb_q;
                if (opb_q != '0) begin
                  state_q <= S_ITER;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                end
              end
              default: begin
                if (opb_q == '0) begin
                  err_q <= 1'b1;
                end else begin
                  acc_q   <= opa_q;
                  cnt_q   <= '0;
                  state_q <= S_ITER;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                end
              end
            endcase
          end
        end
        S_ITER: begin
          if (op_q == OP_MULT) begin
            if (add_co) begin
              err_q   <= 1'b1;
              state_q <= S_FINISH;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              acc_q <= add_y;
              cnt_q <= cnt_dec_d;
              if (cnt_dec_d == '0) begin
                result_q <= add_y;
                state_q  <= S_FINISH;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
              end
            end
          end else if (!add_co) begin
            acc_q <= add_y;
            cnt_q <= cnt_inc_d;
          end else begin
            result_q <= cnt_q;
`ifdef BCD_SEQ_REMAINDER_EN
            rem_q    <= acc_q;
`endif
            state_q  <= S_FINISH;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.neg    = neg_q;
  assign bus.err    = err_q;
  assign bus.state  = state_q;
`ifdef BCD_SEQ_REMAINDER_EN
  assign bus.rem    = rem_q;
`endif
endmodule

// File: tb/tb_bcd_alu_sequencer.sv
// Directed table, corner sequences and random ops against an integer-arithmetic
// model of the BCD sequencer (result, flags and latency).
module tb_bcd_alu_sequencer;
  localparam int DIGITS = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bcd_alu_sequencer_if #(.DIGITS(DIGITS)) bus ();
  bcd_alu_sequencer #(.DIGITS(DIGITS)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        neg;
    logic        err;
    int          lat;
    logic [15:0] rem;
  } vec_t;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int bcd2int(input logic [15:0] x);
    return 1000*int'(x[15:12]) + 100*int'(x[11:8]) + 10*int'(x[7:4]) + int'(x[3:0]);
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  function automatic logic nib_ok(input logic [15:0] x);
    for (int i = 0; i < 4; i++) if (x[i*4 +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  // Reference: plain integer arithmetic; MULT overflow trips on the first
  // partial product above 9999.
  function automatic vec_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    vec_t v;
    int ia, ib;
    v.op = op; v.a = a; v.b = b;
    v.res = '0; v.neg = 1'b0; v.err = 1'b0; v.lat = 2; v.rem = '0;
    if (op < 4'd12 || !nib_ok(a) || !nib_ok(b)) begin
      v.err = 1'b1;
      return v;
    end
    ia = bcd2int(a);
    ib = bcd2int(b);
    case (op)
      4'd12: if (ia + ib > 9999) v.err = 1'b1; else v.res = int2bcd(ia + ib);
      4'd13: if (ia >= ib) v.res = int2bcd(ia - ib);
             else begin v.res = int2bcd(ib - ia); v.neg = 1'b1; end
      4'd14: if (ib != 0) begin
               if (ia * ib > 9999) begin v.err = 1'b1; v.lat = 9999 / ia + 3; end
               else begin v.res = int2bcd(ia * ib); v.lat = ib + 2; end
             end
      default: if (ib == 0) v.err = 1'b1;
               else begin
                 v.res = int2bcd(ia / ib);
                 v.rem = int2bcd(ia % ib);
                 v.lat = ia / ib + 3;
               end
    endcase
    return v;
  endfunction

  task automatic run(input vec_t v, input string tag);
    int   lat;
    logic busy_ok;
    @(negedge clk);
    bus.op = v.op; bus.opa = v.a; bus.opb = v.b; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    busy_ok = 1'b1;
    lat = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      lat++;
      if (bus.done) break;
      if (!bus.busy) busy_ok = 1'b0;
    end
    chk({tag, " latency"}, 32'(lat), 32'(v.lat));
    chk({tag, " result"}, 32'(bus.result), 32'(v.res));
    chk({tag, " neg"}, 32'(bus.neg), 32'(v.neg));
    chk({tag, " err"}, 32'(bus.err), 32'(v.err));
    chk({tag, " busy low at done"}, 32'(bus.busy), 32'(0));
    chk({tag, " busy while running"}, 32'(busy_ok), 32'(1));
`ifdef BCD_SEQ_REMAINDER_EN
    chk({tag, " rem"}, 32'(bus.rem), 32'(v.rem));
`endif
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[$];
    vec_t        v;
    int          lat;
    logic        seen;
    logic [3:0]  rop;
    logic [15:0] ra, rb;

    bus.start = 1'b0; bus.op = '0; bus.opa = '0; bus.opb = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset busy", 32'(bus.busy), 32'(0));
    chk("reset done", 32'(bus.done), 32'(0));
    chk("reset result", 32'(bus.result), 32'(0));
    chk("reset neg", 32'(bus.neg), 32'(0));
    chk("reset err", 32'(bus.err), 32'(0));
    chk("reset state", 32'(bus.state), 32'(0));
`ifdef BCD_SEQ_REMAINDER_EN
    chk("reset rem", 32'(bus.rem), 32'(0));
`endif

    //        op     a         b         res       neg   err   lat   rem
    tbl.push_back('{4'd12, 16'h0123, 16'h0456, 16'h0579, 1'b0, 1'b0, 2,    16'h0000});
    tbl.push_back('{4'd13, 16'h0010, 16'h0025, 16'h0015, 1'b1, 1'b0, 2,    16'h0000});
    tbl.push_back('{4'd14, 16'h0012, 16'h0005, 16'h0060, 1'b0, 1'b0, 7,    16'h0000});
    tbl.push_back('{4'd14, 16'h5000, 16'h0002, 16'h0000, 1'b0, 1'b1, 4,    16'h0000});
    tbl.push_back('{4'd15, 16'h0100, 16'h0007, 16'h0014, 1'b0, 1'b0, 17,   16'h0002});
    tbl.push_back('{4'd15, 16'h0100, 16'h0000, 16'h0000, 1'b0, 1'b1, 2,    16'h0000});
    tbl.push_back('{4'd12, 16'h00A1, 16'h0001, 16'h0000, 1'b0, 1'b1, 2,    16'h0000});
    tbl.push_back('{4'd4,  16'h0012, 16'h0003, 16'h0000, 1'b0, 1'b1, 2,    16'h0000});
    tbl.push_back('{4'd12, 16'h9999, 16'h0001, 16'h0000, 1'b0, 1'b1, 2,    16'h0000});
    tbl.push_back('{4'd12, 16'h9990, 16'h0009, 16'h9999, 1'b0, 1'b0, 2,    16'h0000});
    tbl.push_back('{4'd13, 16'h0500, 16'h0500, 16'h0000, 1'b0, 1'b0, 2,    16'h0000});
    tbl.push_back('{4'd13, 16'h0000, 16'h9999, 16'h9999, 1'b1, 1'b0, 2,    16'h0000});
    tbl.push_back('{4'd13, 16'h0012, 16'h0B00, 16'h0000, 1'b0, 1'b1, 2,    16'h0000});
    tbl.push_back('{4'd14, 16'h0123, 16'h0000, 16'h0000, 1'b0, 1'b0, 2,    16'h0000});
    tbl.push_back('{4'd14, 16'h0003, 16'h0333, 16'h0999, 1'b0, 1'b0, 335,  16'h0000});
    tbl.push_back('{4'd15, 16'h0003, 16'h0007, 16'h0000, 1'b0, 1'b0, 3,    16'h0003});
    tbl.push_back('{4'd15, 16'h0009, 16'h0003, 16'h0003, 1'b0, 1'b0, 6,    16'h0000});
    foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));

    // Reset during the 4th MULT iteration: no done, everything back to idle.
    @(negedge clk);
    bus.op = 4'd14; bus.opa = 16'h0012; bus.opb = 16'h0009; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("midop busy before reset", 32'(bus.busy), 32'(1));
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midop state", 32'(bus.state), 32'(0));
    chk("midop busy", 32'(bus.busy), 32'(0));
    chk("midop done", 32'(bus.done), 32'(0));
    chk("midop result", 32'(bus.result), 32'(0));
    chk("midop err", 32'(bus.err), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (15) begin @(negedge clk); if (bus.done) seen = 1'b1; end
    chk("midop no done", 32'(seen), 32'(0));

    // Start pulses while busy and during FINISH are dropped.
    @(negedge clk);
    bus.op = 4'd15; bus.opa = 16'h0100; bus.opb = 16'h0007; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 3 || lat == 5) begin
        bus.start = 1'b1; bus.op = 4'd12; bus.opa = 16'h0001; bus.opb = 16'h0001;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) break;
    end
    chk("busy-start latency", 32'(lat), 32'(17));
    chk("busy-start result", 32'(bus.result), 32'(16'h0014));
    bus.start = 1'b1; bus.op = 4'd12; bus.opa = 16'h0001; bus.opb = 16'h0001;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    chk("finish-start state", 32'(bus.state), 32'(0));
    chk("finish-start busy", 32'(bus.busy), 32'(0));
    seen = 1'b0;
    repeat (6) begin @(negedge clk); if (bus.done) seen = 1'b1; end
    chk("finish-start no done", 32'(seen), 32'(0));
    chk("result held", 32'(bus.result), 32'(16'h0014));

    for (int i = 0; i < 60; i++) begin
      rop = 4'($urandom_range(12, 15));
      if ($urandom_range(0, 11) == 0) rop = 4'($urandom_range(0, 11));
      ra = ($urandom_range(0, 1) != 0) ? int2bcd($urandom_range(0, 300))
                                       : int2bcd($urandom_range(0, 9999));
      rb = int2bcd($urandom_range(0, 9999));
      if (rop == 4'd14) rb = int2bcd($urandom_range(0, 40));
      if (rop == 4'd15) rb = ($urandom_range(0, 11) == 0) ? 16'h0000
                                                         : int2bcd($urandom_range(100, 9999));
      if ($urandom_range(0, 9) == 0) ra[7:4] = 4'($urandom_range(10, 15));
      v = model(rop, ra, rb);
      run(v, $sformatf("rnd%0d op%0d %h,%h", i, rop, ra, rb));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
